// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game controller: random wait, timed response, result hold.
// Tracks last time, best valid time and a saturating count of valid rounds.
module reaction_timer_ctrl #(
    parameter int TW         = 10,
    parameter int TICK_DIV   = 4,
    parameter int MIN_WAIT   = 8,
    parameter int RW         = 4,
    parameter int RAND_EN    = 1,
    parameter int LATE_LIMIT = 999,
    parameter int HOLD_TICKS = 5
) (
    input  logic          clk,
    input  logic          RESET_n,
    input  logic          start,
    input  logic          enter,
    output logic [2:0]    color_r,
    output logic [2:0]    color_g,
    output logic [2:0]    color_b,
    output logic [TW-1:0] time_val,
    output logic [TW-1:0] best_val,
    output logic [7:0]    rounds,
    output logic [2:0]    state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RWAIT  = 3'd1,
        S_TIMING = 3'd2,
        S_SHOW   = 3'd3,
        S_EARLY  = 3'd4,
        S_LATE   = 3'd5
    } state_t;

    localparam int PW = $clog2(TICK_DIV);
    localparam int WW = $clog2(MIN_WAIT + (1 << RW)) + 1;
    localparam int HW = $clog2(HOLD_TICKS) + 1;

    state_t        state;
    state_t        next_state;
    logic [PW-1:0] presc;
    logic          tick;
    logic [15:0]   lfsr;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_load;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] cnt_now;
    logic [HW-1:0] hold_cnt;
    logic [2:0]    r_next;
    logic [2:0]    g_next;
    logic [2:0]    b_next;
    logic          state_change;

    assign tick         = (presc == PW'(TICK_DIV - 1));
    assign state_change = (next_state != state);
    assign wait_load    = WW'(MIN_WAIT) + ((RAND_EN != 0) ? WW'(lfsr[RW-1:0]) : '0);
    // Count as it stands after this cycle's tick, so a press on the limit tick reads LATE_LIMIT.
    assign cnt_now      = tick ? tick_cnt + TW'(1) : tick_cnt;
    assign state_o      = state;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state   <= S_IDLE;
            color_r <= 3'd0;
            color_g <= 3'd0;
            color_b <= 3'd3;
        end else begin
            state   <= next_state;
            color_r <= r_next;
            color_g <= g_next;
            color_b <= b_next;
        end
    end

    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_RWAIT;
            S_RWAIT: begin
                if (enter)                             next_state = S_EARLY;
                else if (tick && wait_cnt <= WW'(1))   next_state = S_TIMING;
            end
            S_TIMING: begin
                if (enter)                                        next_state = S_SHOW;
                else if (tick && tick_cnt == TW'(LATE_LIMIT - 1)) next_state = S_LATE;
            end
            S_SHOW, S_EARLY, S_LATE: begin
                if (tick && hold_cnt == HW'(HOLD_TICKS - 1)) next_state = S_IDLE;
            end
            default:  next_state = S_IDLE;
        endcase
    end

    // Colour is decoded from the next state so it lands on the same edge as the state.
    always_comb begin
        r_next = 3'd0;
        g_next = 3'd0;
        b_next = 3'd0;
        case (next_state)
            S_IDLE:   b_next = 3'd3;
            S_TIMING: g_next = 3'd7;
            S_SHOW:   begin r_next = 3'd7; g_next = 3'd7; b_next = 3'd7; end
            S_EARLY:  r_next = 3'd7;
            S_LATE:   begin r_next = 3'd7; g_next = 3'd3; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            presc    <= '0;
            lfsr     <= 16'hACE1;
            wait_cnt <= '0;
            tick_cnt <= '0;
            hold_cnt <= '0;
            time_val <= '0;
            best_val <= '1;
            rounds   <= '0;
        end else begin
            // Galois form of x^16+x^14+x^13+x^11+1; a non-zero seed never reaches zero.
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

            if (state_change || tick) presc <= '0;
            else                      presc <= presc + PW'(1);

            if (state == S_IDLE && next_state == S_RWAIT)
                wait_cnt <= wait_load;
            else if (state == S_RWAIT && tick && wait_cnt != '0)
                wait_cnt <= wait_cnt - WW'(1);

            if (state_change)
                tick_cnt <= '0;
            else if (state == S_TIMING && tick && tick_cnt < TW'(LATE_LIMIT))
                tick_cnt <= tick_cnt + TW'(1);

            if (state_change)
                hold_cnt <= '0;
            else if (tick && (state == S_SHOW || state == S_EARLY || state == S_LATE))
                hold_cnt <= hold_cnt + HW'(1);

            if (state == S_TIMING && next_state == S_SHOW) begin
                time_val <= cnt_now;
                if (cnt_now < best_val) best_val <= cnt_now;
                if (rounds != 8'hFF)    rounds   <= rounds + 8'd1;
            end else if (state == S_TIMING && next_state == S_LATE) begin
                time_val <= TW'(LATE_LIMIT);
            end
        end
    end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl with an elapsed-time model checked every cycle.
// Model works from cycles spent in each phase rather than from prescaler/counter registers.
module tb_reaction_timer_ctrl;

    localparam int TW         = 10;
    localparam int TICK_DIV   = 4;
    localparam int MIN_WAIT   = 2;
    localparam int RW         = 4;
    localparam int RAND_EN    = 0;
    localparam int LATE_LIMIT = 20;
    localparam int HOLD_TICKS = 5;
    localparam int ALL_ONES   = (1 << TW) - 1;

    localparam int P_IDLE = 0, P_RWAIT = 1, P_TIMING = 2, P_SHOW = 3, P_EARLY = 4, P_LATE = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          enter;
    logic [2:0]    color_r, color_g, color_b;
    logic [TW-1:0] time_val, best_val;
    logic [7:0]    rounds;
    logic [2:0]    state_o;

    int total = 0;
    int bad   = 0;

    reaction_timer_ctrl #(
        .TW(TW), .TICK_DIV(TICK_DIV), .MIN_WAIT(MIN_WAIT), .RW(RW), .RAND_EN(RAND_EN),
        .LATE_LIMIT(LATE_LIMIT), .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .clk(clk), .RESET_n(rst_n), .start(start), .enter(enter),
        .color_r(color_r), .color_g(color_g), .color_b(color_b),
        .time_val(time_val), .best_val(best_val), .rounds(rounds), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int rgb_of(input int phase);
        case (phase)
            P_IDLE:   return 9'b000_000_011;
            P_TIMING: return 9'b000_111_000;
            P_SHOW:   return 9'b111_111_111;
            P_EARLY:  return 9'b111_000_000;
            P_LATE:   return 9'b111_011_000;
            default:  return 0;
        endcase
    endfunction

    // Model: phase plus number of clock edges spent in it; ticks completed = edges / TICK_DIV.
    int m_phase, m_edges, m_time, m_best, m_rounds;
    int n_edges, n_phase, n_ticks;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  <= P_IDLE;
            m_edges  <= 0;
            m_time   <= 0;
            m_best   <= ALL_ONES;
            m_rounds <= 0;
        end else begin
            n_edges = m_edges + 1;
            n_phase = m_phase;
            n_ticks = n_edges / TICK_DIV;
            case (m_phase)
                P_IDLE:  if (start) n_phase = P_RWAIT;
                P_RWAIT: begin
                    if (enter)                              n_phase = P_EARLY;
                    else if (n_edges == MIN_WAIT * TICK_DIV) n_phase = P_TIMING;
                end
                P_TIMING: begin
                    if (enter) begin
                        n_phase = P_SHOW;
                        m_time  <= n_ticks;
                        if (n_ticks < m_best) m_best <= n_ticks;
                        if (m_rounds < 255)   m_rounds <= m_rounds + 1;
                    end else if (n_ticks == LATE_LIMIT) begin
                        n_phase = P_LATE;
                        m_time  <= LATE_LIMIT;
                    end
                end
                default: if (n_edges == HOLD_TICKS * TICK_DIV) n_phase = P_IDLE;
            endcase
            m_phase <= n_phase;
            m_edges <= (n_phase != m_phase) ? 0 : n_edges;
        end
    end

    always @(negedge clk) begin
        check("state",  int'(state_o), m_phase);
        check("colour", int'({color_r, color_g, color_b}), rgb_of(m_phase));
        check("time",   int'(time_val), m_time);
        check("best",   int'(best_val), m_best);
        check("rounds", int'(rounds), m_rounds);
    end

    task automatic wait_state(input int code, input int max_cycles, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (int'(state_o) != code && cycles < max_cycles);
        check("wait_state", int'(state_o), code);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rwait_entry", int'(state_o), P_RWAIT);
    endtask

    task automatic pulse_enter();
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        start = 1'b0;
        enter = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_state",  int'(state_o), P_IDLE);
        check("rst_colour", int'({color_r, color_g, color_b}), 9'b000_000_011);
        check("rst_time",   int'(time_val), 0);
        check("rst_best",   int'(best_val), ALL_ONES);
        check("rst_rounds", int'(rounds), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Round 1: TIMING 8 clk after RWAIT entry, press 12 clk into TIMING -> 3 ticks.
        do_start();
        wait_state(P_TIMING, 50, cyc);
        check("r1_wait_len", cyc, 8);
        check("r1_green", int'({color_r, color_g, color_b}), 9'b000_111_000);
        repeat (12) @(negedge clk);
        pulse_enter();
        check("r1_show",   int'(state_o), P_SHOW);
        check("r1_time",   int'(time_val), 3);
        check("r1_best",   int'(best_val), 3);
        check("r1_rounds", int'(rounds), 1);
        wait_state(P_IDLE, 40, cyc);
        check("r1_hold_len", cyc, 20);

        // Round 2: 5 ticks, best stays 3; start/enter during hold are ignored.
        do_start();
        wait_state(P_TIMING, 50, cyc);
        repeat (20) @(negedge clk);
        pulse_enter();
        check("r2_time",   int'(time_val), 5);
        check("r2_best",   int'(best_val), 3);
        check("r2_rounds", int'(rounds), 2);
        start = 1'b1;
        enter = 1'b1;
        @(negedge clk);
        start = 1'b0;
        enter = 1'b0;
        check("r2_hold_ignores", int'(state_o), P_SHOW);
        wait_state(P_IDLE, 40, cyc);
        check("r2_hold_len", cyc, 19);

        // Early press during the random wait.
        do_start();
        repeat (3) @(negedge clk);
        pulse_enter();
        check("early_state",  int'(state_o), P_EARLY);
        check("early_colour", int'({color_r, color_g, color_b}), 9'b111_000_000);
        check("early_time",   int'(time_val), 5);
        check("early_rounds", int'(rounds), 2);
        wait_state(P_IDLE, 40, cyc);
        check("early_hold_len", cyc, 20);

        // No press: LATE exactly 80 clk after TIMING entry.
        do_start();
        wait_state(P_TIMING, 50, cyc);
        wait_state(P_LATE, 100, cyc);
        check("late_len",    cyc, 80);
        check("late_time",   int'(time_val), LATE_LIMIT);
        check("late_colour", int'({color_r, color_g, color_b}), 9'b111_011_000);
        check("late_rounds", int'(rounds), 2);
        wait_state(P_IDLE, 40, cyc);

        // Press on the very cycle the limit is reached: SHOW wins with time 20.
        do_start();
        wait_state(P_TIMING, 50, cyc);
        repeat (79) @(negedge clk);
        pulse_enter();
        check("limit_show",   int'(state_o), P_SHOW);
        check("limit_time",   int'(time_val), LATE_LIMIT);
        check("limit_best",   int'(best_val), 3);
        check("limit_rounds", int'(rounds), 3);
        wait_state(P_IDLE, 40, cyc);

        // Reset pulse mid-TIMING, away from any clock edge.
        do_start();
        wait_state(P_TIMING, 50, cyc);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_state",  int'(state_o), P_IDLE);
        check("mid_rst_colour", int'({color_r, color_g, color_b}), 9'b000_000_011);
        check("mid_rst_best",   int'(best_val), ALL_ONES);
        check("mid_rst_rounds", int'(rounds), 0);
        check("mid_rst_time",   int'(time_val), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        wait_state(P_TIMING, 50, cyc);
        check("post_rst_wait_len", cyc, 8);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
